// File: rtl/rom_dl_writer.sv
// rom_dl_writer: ioctl download words -> FIFO -> byte-swapped toggle-handshake ddram writes; define ROM_DL_CHECKSUM_EN for the Genesis header checksum
module rom_dl_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 25
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [15:0]       dl_data,
  output logic              dl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] rom_size,
  output logic              overflow,
  output logic              done
`ifdef ROM_DL_CHECKSUM_EN
  ,
  output logic [15:0]       checksum,
  output logic              checksum_ok
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] HWM_C = (PW+1)'(FIFO_DEPTH - 1);
  typedef enum logic [1:0] {SYNC, IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [ADDR_W+15:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count, count_n;
  logic act_q, rise, fall, wr_req, full, push, drop, pop, settled, flush, drain_ok;
  logic [ADDR_W-1:0] size_cand;
  logic [15:0] swapped;
  // edge detection, FIFO accounting and next-state decode
  always_comb begin
    rise = dl_active & ~act_q;
    fall = ~dl_active & act_q;
    settled = mem_ack == mem_req;
    wr_req = dl_wr & dl_active;
    full = (count == FULL_C) & ~rise;
    push = wr_req & ~full;
    drop = wr_req & full;
    pop = (state == IDLE) & (count != '0) & ~rise;
    count_n = rise ? (PW+1)'(push) : count + (PW+1)'(push) - (PW+1)'(pop);
    swapped = {dl_data[7:0], dl_data[15:8]};
    size_cand = dl_addr + ADDR_W'(2);
    drain_ok = flush & (count == '0) & settled;
    state_n = (state == SYNC && settled) ? IDLE :
              (state == IDLE && pop) ? WAIT :
              (state == WAIT && settled) ? IDLE : state;
  end
  // FIFO storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk_sys)
    if (push) fifo[rise ? PW'(0) : wr_ptr] <= {dl_addr, swapped};
  // control state, write request issue and download bookkeeping
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state <= SYNC;
      act_q <= 1'b0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      dl_wait <= 1'b0;
      mem_addr <= '0;
      mem_din <= '0;
      mem_req <= 1'b0;
      rom_size <= '0;
      overflow <= 1'b0;
      flush <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      act_q <= dl_active;
      count <= count_n;
      wr_ptr <= rise ? PW'(push) : wr_ptr + PW'(push);
      rd_ptr <= rise ? PW'(0) : rd_ptr + PW'(pop);
      dl_wait <= (state_n == SYNC) | (count_n >= HWM_C);
      if (pop) begin
        {mem_addr, mem_din} <= fifo[rd_ptr];
        mem_req <= ~mem_req;
      end
      rom_size <= rise ? (push ? size_cand : '0) : (push && size_cand > rom_size) ? size_cand : rom_size;
      overflow <= (overflow & ~rise) | drop;
      flush <= rise ? 1'b0 : fall ? 1'b1 : drain_ok ? 1'b0 : flush;
      done <= drain_ok & ~rise;
    end
`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0] hdr;
  // header word capture and sum of body words from 0x200 up, checked when the download drains
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      checksum <= '0;
      hdr <= '0;
      checksum_ok <= 1'b0;
    end else begin
      checksum <= (rise ? 16'h0 : checksum) + ((push && dl_addr >= ADDR_W'(12'h200)) ? swapped : 16'h0);
      hdr <= (push && dl_addr == ADDR_W'(12'h18E)) ? swapped : rise ? 16'h0 : hdr;
      checksum_ok <= rise ? 1'b0 : (drain_ok ? checksum == hdr : checksum_ok);
    end
`endif
endmodule

// File: tb/tb_rom_dl_writer.sv
// tb_rom_dl_writer: directed stimulus with a queue-based reference model checked every cycle
module tb_rom_dl_writer;
  localparam int DEPTH = 4;
  localparam int AW = 25;
  logic clk_sys = 1'b0, reset_n = 1'b0, dl_active = 1'b0, dl_wr = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] dl_addr = '0;
  logic [15:0] dl_data = '0;
  logic dl_wait, mem_req, overflow, done;
  logic [AW-1:0] mem_addr, rom_size;
  logic [15:0] mem_din;
`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0] checksum;
  logic checksum_ok;
`endif
  rom_dl_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_req(mem_req), .mem_ack(mem_ack), .rom_size(rom_size),
    .overflow(overflow), .done(done)
`ifdef ROM_DL_CHECKSUM_EN
    , .checksum(checksum), .checksum_ok(checksum_ok)
`endif
  );
  always #5 clk_sys = ~clk_sys;

  int total = 0, bad = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: pending (not yet issued) words in arrival order
  logic [AW+15:0] q[$];
  logic [AW-1:0] m_size, cand;
  logic m_ovf, m_prev_act, m_flush, m_sync, prev_req, exp_done;
  logic [15:0] m_sum, m_hdr, sw;
  logic m_ok;
  logic s_wr, s_act, s_ack;
  logic [AW-1:0] s_addr;
  logic [15:0] s_data;
  logic [AW+15:0] head;
  int wcount = 0, dones = 0;
  logic [AW-1:0] wlog_a[256];
  logic [15:0] wlog_d[256];
  bit stall = 0;
  int ack_lat = 3, ack_cnt = 0;

  initial forever begin
    @(posedge clk_sys);
    s_wr = dl_wr; s_act = dl_active; s_addr = dl_addr; s_data = dl_data; s_ack = mem_ack;
    #1;
    if (!reset_n) begin
      q.delete();
      m_size = '0; m_ovf = 0; m_prev_act = 0; m_flush = 0; m_sync = 1; prev_req = 0;
      m_sum = '0; m_hdr = '0; m_ok = 0;
      chk("reset_outputs", {25'd0, dl_wait, mem_req, overflow, done, |rom_size, |mem_addr, |mem_din}, 32'd0);
    end else begin
      exp_done = m_flush && q.size() == 0 && s_ack == prev_req && !(s_act && !m_prev_act);
      if (exp_done) begin m_flush = 0; m_ok = (m_sum == m_hdr); end
      if (s_ack == prev_req) m_sync = 0;
      if (s_act && !m_prev_act) begin
        q.delete(); m_size = '0; m_ovf = 0; m_flush = 0; m_sum = '0; m_hdr = '0; m_ok = 0;
      end
      if (!s_act && m_prev_act) m_flush = 1;
      m_prev_act = s_act;
      if (s_wr && s_act) begin
        if (q.size() == DEPTH) m_ovf = 1;
        else begin
          sw = {s_data[7:0], s_data[15:8]};
          q.push_back({s_addr, sw});
          cand = s_addr + AW'(2);
          if (cand > m_size) m_size = cand;
          if (s_addr >= AW'(12'h200)) m_sum = m_sum + sw;
          if (s_addr == AW'(12'h18E)) m_hdr = sw;
        end
      end
      if (mem_req != prev_req) begin
        chk("no_toggle_while_outstanding", 32'(s_ack), 32'(prev_req));
        chk("toggle_has_pending_word", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          head = q.pop_front();
          chk("mem_addr", 32'(mem_addr), 32'(head[AW+15:16]));
          chk("mem_din", 32'(mem_din), 32'(head[15:0]));
          wlog_a[wcount[7:0]] = mem_addr;
          wlog_d[wcount[7:0]] = mem_din;
          wcount++;
        end
      end
      prev_req = mem_req;
      chk("rom_size", 32'(rom_size), 32'(m_size));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("done", 32'(done), 32'(exp_done));
      chk("dl_wait", 32'(dl_wait), 32'(m_sync || q.size() >= DEPTH - 1));
`ifdef ROM_DL_CHECKSUM_EN
      chk("checksum", 32'(checksum), 32'(m_sum));
      chk("checksum_ok", 32'(checksum_ok), 32'(m_ok));
`endif
      if (done) dones++;
    end
  end

  // ddram responder: completes each request ack_lat cycles after it is seen
  initial forever begin
    @(posedge clk_sys);
    #2;
    if (!reset_n) ack_cnt = 0;
    else if (mem_ack != mem_req && !stall) begin
      if (ack_cnt >= ack_lat - 1) begin mem_ack = mem_req; ack_cnt = 0; end
      else ack_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #3;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
    dl_wr = 1; dl_addr = a; dl_data = d;
    tick();
    dl_wr = 0;
  endtask
  task automatic finish_dl();
    int base, i;
    base = dones;
    stall = 0;
    dl_active = 0;
    for (i = 0; i < 300 && dones == base; i++) tick();
    repeat (5) tick();
    chk("done_pulse_count", 32'(dones - base), 32'd1);
  endtask

  initial begin
    int base, n, i;
    bit saw_wait;
    logic [AW-1:0] a;
    repeat (3) tick();
    chk("reset_dl_wait", 32'(dl_wait), 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    reset_n = 1;
    repeat (3) tick();
    chk("idle_dl_wait", 32'(dl_wait), 32'd0);
    // basic download of three words
    dl_active = 1; tick();
    wr(0, 16'h1234); wr(2, 16'h5678); wr(4, 16'h9ABC);
    finish_dl();
    chk("t2_writes", 32'(wcount), 32'd3);
    chk("t2_a0", 32'(wlog_a[0]), 32'd0);
    chk("t2_a1", 32'(wlog_a[1]), 32'd2);
    chk("t2_a2", 32'(wlog_a[2]), 32'd4);
    chk("t2_d0", 32'(wlog_d[0]), 32'h3412);
    chk("t2_d1", 32'(wlog_d[1]), 32'h7856);
    chk("t2_d2", 32'(wlog_d[2]), 32'hBC9A);
    chk("t2_rom_size", 32'(rom_size), 32'd6);
    // strobes outside a download are ignored
    wr(25'h100, 16'hFFFF); wr(25'h102, 16'hEEEE);
    repeat (4) tick();
    chk("t6_rom_size", 32'(rom_size), 32'd6);
    chk("t6_writes", 32'(wcount), 32'd3);
    // stalled ack, host honours dl_wait
    base = wcount; n = 0; saw_wait = 0; a = 25'h20;
    stall = 1; dl_active = 1; tick();
    for (i = 0; i < 20; i++) begin
      saw_wait |= dl_wait;
      if (!dl_wait) begin dl_wr = 1; dl_addr = a; dl_data = 16'(16'hA000 + i); a += 2; n++; end
      else dl_wr = 0;
      tick();
    end
    dl_wr = 0;
    chk("t3_saw_wait", 32'(saw_wait), 32'd1);
    chk("t3_accepted", 32'(n), 32'd4);
    chk("t3_overflow", 32'(overflow), 32'd0);
    finish_dl();
    chk("t3_writes", 32'(wcount - base), 32'(n));
    // stalled ack, host ignores dl_wait
    base = wcount;
    stall = 1; dl_active = 1; tick();
    for (i = 0; i < 6; i++) wr(AW'(25'h40 + 2 * i), 16'(16'h5500 + i));
    chk("t4_overflow", 32'(overflow), 32'd1);
    finish_dl();
    chk("t4_writes", 32'(wcount - base), 32'd5);
    chk("t4_rom_size", 32'(rom_size), 32'h4A);
    chk("t4_overflow_sticky", 32'(overflow), 32'd1);
`ifdef ROM_DL_CHECKSUM_EN
    dl_active = 1; tick();
    wr(25'h18E, 16'h0300); wr(25'h200, 16'h0100); wr(25'h202, 16'h0200);
    finish_dl();
    chk("t5_checksum", 32'(checksum), 32'h0003);
    chk("t5_ok", 32'(checksum_ok), 32'd1);
    dl_active = 1; tick();
    wr(25'h18E, 16'h0300); wr(25'h200, 16'h0100); wr(25'h202, 16'h0300);
    finish_dl();
    chk("t5_checksum_bad", 32'(checksum), 32'h0004);
    chk("t5_ok_bad", 32'(checksum_ok), 32'd0);
`endif
    // reset with a write in flight, ddram ack arriving afterwards
    dl_active = 1; tick();
    stall = 1;
    wr(25'h10, 16'h1111); wr(25'h12, 16'h2222);
    tick();
    reset_n = 0;
    mem_ack = ~mem_req;
    if (mem_ack == 1'b0) mem_ack = 1'b1;
    dl_active = 0;
    repeat (2) tick();
    chk("t1_rst_mem_req", 32'(mem_req), 32'd0);
    chk("t1_rst_rom_size", 32'(rom_size), 32'd0);
    chk("t1_rst_dl_wait", 32'(dl_wait), 32'd0);
    reset_n = 1;
    repeat (5) tick();
    chk("t1_sync_wait", 32'(dl_wait), 32'd1);
    chk("t1_sync_no_toggle", 32'(mem_req), 32'd0);
    stall = 0;
    for (i = 0; i < 20 && dl_wait; i++) tick();
    chk("t1_sync_release", 32'(dl_wait), 32'd0);
    chk("t1_ack_returned", 32'(mem_ack), 32'd0);
    base = wcount;
    dl_active = 1; tick();
    wr(25'h0, 16'hAA55);
    finish_dl();
    chk("t1_post_writes", 32'(wcount - base), 32'd1);
    chk("t1_post_din", 32'(wlog_d[8'(wcount - 1)]), 32'h55AA);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
